mul_seq_param: RTL and testbench



---
 rtl/mul_pkg.sv | 23 ++
 rtl/acc_window_extract.sv | 22 ++
 rtl/mul_seq_param.sv | 133 +++++++++++++
 tb/tb_mul_seq_param.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the parametrised sequential multiplier.
//   mul_state_t : IDLE / RUN / DONE controller states
//   iter_count  : number of RUN iterations for a given operand width and step
//   bpc_legal   : parameter legality test used at elaboration time
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mul_state_t;

    function automatic int iter_count(input int width, input int bits_per_cycle);
        return width / bits_per_cycle;
    endfunction

    // Step must be 1, 2 or 4 and must split the operand into whole digits.
    function automatic bit bpc_legal(input int width, input int bits_per_cycle);
        return ((bits_per_cycle == 1) || (bits_per_cycle == 2) || (bits_per_cycle == 4))
               && ((width % bits_per_cycle) == 0);
    endfunction

endpackage

// File: rtl/acc_window_extract.sv
// Combinational sliding-window selector over the product accumulator.
//   acc   in  ACC_W  accumulator contents
//   index in  IDX_W  window position, in units of STEP bits
//   win   out WIN_W  acc[index*STEP +: WIN_W], zero-padded above ACC_W
module acc_window_extract #(
    parameter int ACC_W = 32,
    parameter int WIN_W = 17,
    parameter int STEP  = 1,
    localparam int IDX_W = ((ACC_W / STEP) > 1) ? $clog2(ACC_W / STEP) : 1
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [IDX_W-1:0] index,
    output logic [WIN_W-1:0] win
);

    // Padding above the accumulator so a window reaching past the top reads zeros.
    logic [ACC_W+WIN_W-1:0] padded;

    assign padded = {{WIN_W{1'b0}}, acc};
    assign win    = WIN_W'(padded >> (index * STEP));

endmodule

// File: rtl/mul_seq_param.sv
// Iterative shift-and-add multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, is_signed sampled on accept)
//   a, b                  multiplicand / multiplier, WIDTH bits
//   is_signed             two's-complement operands (ignored when SIGNED_EN=0)
//   out_valid / out_ready product handshake
//   product               exact 2*WIDTH-bit result, held until handed off
//   busy                  high while an operation is in RUN or DONE
module mul_seq_param
    import mul_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1,
    parameter bit SIGNED_EN      = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int B     = BITS_PER_CYCLE;
    localparam int N     = iter_count(WIDTH, BITS_PER_CYCLE);
    localparam int PW    = 2 * WIDTH;
    localparam int WIN_W = WIDTH + B;
    localparam int KW    = ((PW / B) > 1) ? $clog2(PW / B) : 1;

    if (!bpc_legal(WIDTH, BITS_PER_CYCLE)) begin : g_param_check
        $error("mul_seq_param: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
    end

    mul_state_t        state, state_next;
    logic [KW-1:0]     k;
    logic [WIDTH-1:0]  a_mag_q, b_mag_q;
    logic              neg_q;
    logic [PW-1:0]     acc, acc_next;

    logic              signed_op;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [B-1:0]      d;
    logic [WIN_W-1:0]  win, win_sum;
    logic              last_iter;

    // Magnitudes of the incoming operands; -2^(WIDTH-1) negates to itself,
    // which is exactly its magnitude when read unsigned.
    assign signed_op = SIGNED_EN && is_signed;
    assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

    assign last_iter = (k == KW'(N - 1));
    assign d         = B'(b_mag_q >> (k * B));

    acc_window_extract #(
        .ACC_W (PW),
        .WIN_W (WIN_W),
        .STEP  (B)
    ) u_win (
        .acc   (acc),
        .index (k),
        .win   (win)
    );

    // The window holds at most |a|*(2^(kB)-1)/2^(kB) + |a|*d < 2^(WIDTH+B): no carry out.
    assign win_sum  = win + WIN_W'(a_mag_q) * WIN_W'(d);
    assign acc_next = (acc & ~(PW'({WIN_W{1'b1}}) << (k * B)))
                    | (PW'(win_sum) << (k * B));

    // NOTE: every output and next-state variable gets a default before the case,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            k       <= '0;
            acc     <= '0;
            a_mag_q <= '0;
            b_mag_q <= '0;
            neg_q   <= 1'b0;
            product <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_mag_q <= a_mag;
                        b_mag_q <= b_mag;
                        neg_q   <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc     <= '0;
                        k       <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    k   <= k + 1'b1;
                    if (last_iter) product <= neg_q ? -acc_next : acc_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_param.sv
// Bench for mul_seq_param: unit 0 is WIDTH=16/B=1, unit 1 is WIDTH=16/B=4,
// both with signed support; results are compared against plain integer arithmetic.
module tb_mul_seq_param;

    logic        clk;
    logic        rst_n;
    logic [15:0] a, b;
    logic        is_signed;
    logic [1:0]  in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] product [2];

    int n_tests = 0;
    int n_fail  = 0;

    mul_seq_param #(.WIDTH(16), .BITS_PER_CYCLE(1), .SIGNED_EN(1'b1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .product(product[0]), .busy(busy[0])
    );

    mul_seq_param #(.WIDTH(16), .BITS_PER_CYCLE(4), .SIGNED_EN(1'b1)) u_b4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .product(product[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                            input bit sgn);
        longint p;
        if (sgn) p = longint'($signed(x)) * longint'($signed(y));
        else     p = longint'(x) * longint'(y);
        return p[31:0];
    endfunction

    function automatic int iters(input int u);
        return (u == 0) ? 16 : 4;
    endfunction

    // Full transaction on unit u. Operands are scrambled right after the accept
    // edge so the result must come from the latched values.
    task automatic do_op(input int u, input logic [15:0] x, input logic [15:0] y,
                         input bit sgn, output logic [31:0] res, output int lat,
                         output bit ready_low);
        @(negedge clk);
        a = x; b = y; is_signed = sgn; in_valid[u] = 1'b1;
        check("ready before accept", in_ready[u], 1'b1);
        @(posedge clk);
        lat = 0;
        ready_low = 1'b1;
        @(negedge clk);
        in_valid[u] = 1'b0;
        a = 16'($urandom); b = 16'($urandom); is_signed = 1'($urandom);
        while (!out_valid[u] && lat < 100) begin
            if (in_ready[u]) ready_low = 1'b0;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (lat >= 100) check("out_valid timeout", 1'b0, 1'b1);
        res = product[u];
        out_ready[u] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[u] = 1'b0;
    endtask

    logic [31:0] res;
    int          lat;
    bit          rdy_low;
    logic [15:0] corners [5] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};

    function automatic logic [15:0] pick(input logic [15:0] c [5]);
        if ($urandom_range(3) == 0) return c[$urandom_range(4)];
        return 16'($urandom);
    endfunction

    initial begin
        rst_n = 1'b0; in_valid = '0; out_ready = '0;
        a = '0; b = '0; is_signed = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("reset in_ready u%0d", u), in_ready[u], 1'b1);
            check($sformatf("reset out_valid u%0d", u), out_valid[u], 1'b0);
            check($sformatf("reset busy u%0d", u), busy[u], 1'b0);
            check($sformatf("reset product u%0d", u), product[u], 32'h0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Unsigned full-scale on the bit-serial unit.
        do_op(0, 16'hFFFF, 16'hFFFF, 1'b0, res, lat, rdy_low);
        check("b1 ffff*ffff", res, 32'hFFFE0001);
        check("b1 latency", lat, 16);
        check("b1 in_ready low during op", rdy_low, 1'b1);

        // Signed cases on the 4-bit-digit unit.
        do_op(1, 16'hFFFD, 16'd7, 1'b1, res, lat, rdy_low);
        check("b4 -3*7", res, 32'hFFFFFFEB);
        check("b4 latency", lat, 4);
        do_op(1, 16'h8000, 16'h8000, 1'b1, res, lat, rdy_low);
        check("b4 min*min", res, 32'h40000000);
        do_op(0, 16'h8000, 16'h8000, 1'b1, res, lat, rdy_low);
        check("b1 min*min", res, 32'h40000000);

        // Operand hold.
        do_op(0, 16'd12, 16'd10, 1'b0, res, lat, rdy_low);
        check("b1 hold 12*10", res, 32'd120);

        // Backpressure on unit 1: 100 * -2 = -200.
        @(negedge clk);
        a = 16'd100; b = 16'hFFFE; is_signed = 1'b1; in_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        lat = 0;
        while (!out_valid[1] && lat < 100) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("bp out_valid", out_valid[1], 1'b1);
        check("bp product", product[1], 32'hFFFFFF38);
        for (int i = 0; i < 5; i++) begin
            in_valid[1] = i[0];
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp hold out_valid", out_valid[1], 1'b1);
            check("bp hold product", product[1], 32'hFFFFFF38);
            check("bp hold in_ready", in_ready[1], 1'b0);
        end
        in_valid[1] = 1'b0;
        out_ready[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[1] = 1'b0;
        check("bp release in_ready", in_ready[1], 1'b1);
        check("bp release out_valid", out_valid[1], 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("bp no queued op", busy[1], 1'b0);

        // Reset during iteration 7 of 16 on unit 0.
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; is_signed = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", out_valid[0], 1'b0);
        check("midrst product", product[0], 32'h0);
        check("midrst in_ready", in_ready[0], 1'b1);
        check("midrst busy", busy[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 16'd5, 16'd6, 1'b0, res, lat, rdy_low);
        check("after reset 5*6", res, 32'd30);

        // Random regression per (unit, signedness).
        for (int u = 0; u < 2; u++) begin
            for (int s = 0; s < 2; s++) begin
                for (int n = 0; n < 600; n++) begin
                    logic [15:0] x, y;
                    x = pick(corners);
                    y = pick(corners);
                    do_op(u, x, y, s[0], res, lat, rdy_low);
                    check($sformatf("rand u%0d s%0d %h*%h", u, s, x, y), res,
                          ref_mul(x, y, s[0]));
                    check($sformatf("rand latency u%0d", u), lat, iters(u));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
